// File: rtl/regfile_dump_reader_if.sv
// Dump output stream: one register entry (index + value) per valid/ready handshake.
//   master : drives out_valid/out_data/out_index, samples out_ready
//   slave  : samples out_valid/out_data/out_index, drives out_ready
interface regfile_dump_reader_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
) ();
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_index;

   modport master (output out_valid, output out_data, output out_index, input out_ready);
   modport slave  (input out_valid, input out_data, input out_index, output out_ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks a register-file read port from first_reg up to NUM_REGS-1 and streams
// each value with its index over a valid/ready interface (debug dump / compare).
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start,first_reg begin a dump at first_reg (sampled in IDLE only)
//   abort           cancel from any state, back to IDLE on the next edge
//   rd_addr,rd_data shared register-file read port (address registered)
//   dump            output stream (out_valid/out_ready/out_data/out_index)
//   busy, done      busy in READ/SEND; one-cycle done after the last entry
module regfile_dump_reader #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DATA_W   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    first_reg,
   input  logic                 abort,
   output logic [ADDR_W-1:0]    rd_addr,
   input  logic [DATA_W-1:0]    rd_data,
   regfile_dump_reader_if.master dump,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned   EXT_W    = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_SEND, ST_DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0] index_q, index_d;
   logic              busy_q, done_q;

   // first_reg >= NUM_REGS, via the borrow of an extended subtraction
   logic [EXT_W-1:0]  first_diff;
   logic              first_oob;
   logic              handshake;

   assign first_diff = {1'b0, first_reg} - EXT_W'(NUM_REGS);
   assign first_oob  = ~first_diff[ADDR_W];
   assign handshake  = valid_q & dump.out_ready;

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      valid_d   = valid_q;
      data_d    = data_q;
      index_d   = index_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (first_oob) begin
                  state_d = ST_DONE;
               end else begin
                  rd_addr_d = first_reg;
                  state_d   = ST_READ;
               end
            end
         end
         ST_READ: begin
            // rd_data reflects the file before any same-edge write
            data_d  = rd_data;
            index_d = rd_addr_q;
            valid_d = 1'b1;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (handshake) begin
               valid_d = 1'b0;
               if (index_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  rd_addr_d = rd_addr_q + ADDR_W'(1);
                  state_d   = ST_READ;
               end
            end
         end
         ST_DONE: begin
            rd_addr_d = '0;
            state_d   = ST_IDLE;
         end
         default: begin
            rd_addr_d = '0;
            valid_d   = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase

      // abort overrides everything, including a start in IDLE
      if (abort) begin
         state_d   = ST_IDLE;
         valid_d   = 1'b0;
         rd_addr_d = '0;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rd_addr_q <= '0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         index_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         index_q   <= index_d;
         busy_q    <= (state_d == ST_READ) || (state_d == ST_SEND);
         done_q    <= (state_d == ST_DONE);
      end
   end

   assign rd_addr        = rd_addr_q;
   assign dump.out_valid = valid_q;
   assign dump.out_data  = data_q;
   assign dump.out_index = index_q;
   assign busy           = busy_q;
   assign done           = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a register file beside the DUT, a stream
// monitor, and an expected-entry list built from the register contents.
module tb_regfile_dump_reader;

   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned DATA_W   = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] idx;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic              clk = 1'b0;
   logic              rst, start, abort;
   logic [ADDR_W-1:0] first_reg, rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              busy, done;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rf [NUM_REGS];
   logic [DATA_W-1:0] mem [NUM_REGS];

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;

   entry_t got [$];

   logic              hold_prev = 1'b0;
   logic [DATA_W-1:0] prev_data;
   logic [ADDR_W-1:0] prev_idx;

   always #5 clk = ~clk;

   regfile_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dump_if ();

   regfile_dump_reader #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .first_reg(first_reg),
      .abort    (abort),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .dump     (dump_if),
      .busy     (busy),
      .done     (done)
   );

   // Register file: write on the clock edge, combinational read
   always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;
   assign rd_data = rf[rd_addr];

   task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
      n_cmp++;
      if (got_v !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
      end
   endtask

   // Stream monitor: collect handshakes, check hold stability and done/busy exclusion
   always @(negedge clk) begin
      if (hold_prev && !rst && !abort) begin
         check("hold_valid", 64'(dump_if.out_valid), 64'(1'b1));
         check("hold_data", 64'(dump_if.out_data), 64'(prev_data));
         check("hold_index", 64'(dump_if.out_index), 64'(prev_idx));
      end
      if (!rst && !abort && dump_if.out_valid && dump_if.out_ready)
         got.push_back('{idx: dump_if.out_index, data: dump_if.out_data});
      if (done) begin
         done_cnt++;
         check("done_vs_busy", 64'(busy), 64'(1'b0));
      end
      hold_prev = dump_if.out_valid && !dump_if.out_ready && !abort && !rst;
      prev_data = dump_if.out_data;
      prev_idx  = dump_if.out_index;
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rd_addr"}, 64'(rd_addr), 64'(0));
      check({tag, "_valid"}, 64'(dump_if.out_valid), 64'(0));
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_done"}, 64'(done), 64'(0));
   endtask

   // Fill the register file through its write port (random or A500_0000+k pattern)
   task automatic preload(input bit rnd);
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         mem[i]  = rnd ? DATA_W'($urandom) : (32'hA500_0000 + DATA_W'(i));
         if (i == 0) mem[i] = '0;
         wr_en   = 1'b1;
         wr_addr = ADDR_W'(i);
         wr_data = mem[i];
         @(posedge clk); #1;
      end
      wr_en = 1'b0;
   endtask

   // One full dump; rmode 0 = ready always high, 1 = random stalls.
   // poke: pulse start mid-dump; coh: write R5 during READ5 and R6 one cycle earlier than READ6.
   task automatic run_dump(input int first, input int rmode, input bit poke, input bit coh, input bit chk_lat);
      entry_t exp [$];
      int     n = 0;
      int     stage = 0;
      bit     poked = 1'b0;
      for (int i = first; i < int'(NUM_REGS); i++)
         exp.push_back('{idx: ADDR_W'(i), data: (coh && i == 6) ? 32'hDEAD_BEEF : mem[i]});
      got.delete();
      start = 1'b1;
      first_reg = ADDR_W'(first);
      dump_if.out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n = 1;
      while (!done && n < 400) begin
         start = 1'b0;
         wr_en = 1'b0;
         dump_if.out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (poke && !poked && dump_if.out_valid && dump_if.out_index == ADDR_W'(10)) begin
            start = 1'b1;
            first_reg = ADDR_W'(20);
            poked = 1'b1;
         end
         if (coh) begin
            if (stage == 0 && busy && !dump_if.out_valid && rd_addr == ADDR_W'(5)) begin
               wr_en = 1'b1; wr_addr = ADDR_W'(5); wr_data = 32'hDEAD_BEEF; stage = 1;
            end else if (stage == 1) begin
               wr_en = 1'b1; wr_addr = ADDR_W'(6); wr_data = 32'hDEAD_BEEF; stage = 2;
            end
         end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      wr_en = 1'b0;
      check("done_seen", 64'(done), 64'(1'b1));
      check("done_busy_low", 64'(busy), 64'(1'b0));
      if (chk_lat) check("done_latency", 64'(n), 64'(2 * (int'(NUM_REGS) - first) + 1));
      check("entry_count", 64'(got.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         check("entry_index", 64'(got[i].idx), 64'(exp[i].idx));
         check("entry_data", 64'(got[i].data), 64'(exp[i].data));
      end
      if (coh) begin
         mem[5] = 32'hDEAD_BEEF;
         mem[6] = 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
      check_idle_outputs("after_done");
   endtask

   // Start a dump with ready high and wait until entry `idx` is being offered
   task automatic dump_until(input int idx);
      int n = 0;
      got.delete();
      start = 1'b1;
      first_reg = '0;
      dump_if.out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (!(dump_if.out_valid && dump_if.out_index == ADDR_W'(idx)) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("reach_index", 64'(dump_if.out_index), 64'(idx));
   endtask

   initial begin
      int d0;
      int first;
      int rmode;
      rst = 1'b1; start = 1'b0; abort = 1'b0; first_reg = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      dump_if.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      check("reset_data", 64'(dump_if.out_data), 64'(0));
      check("reset_index", 64'(dump_if.out_index), 64'(0));
      rst = 1'b0;

      preload(1'b0);
      run_dump(0, 0, 1'b0, 1'b0, 1'b1);
      run_dump(0, 1, 1'b0, 1'b0, 1'b0);
      run_dump(30, 0, 1'b0, 1'b0, 1'b1);
      run_dump(31, 0, 1'b0, 1'b0, 1'b1);

      // Abort while entry 7 is stalled
      dump_until(7);
      dump_if.out_ready = 1'b0;
      abort = 1'b1;
      d0 = done_cnt;
      @(posedge clk); #1;
      abort = 1'b0;
      check_idle_outputs("abort");
      repeat (5) @(posedge clk);
      #1;
      check("abort_no_done", 64'(done_cnt), 64'(d0));
      check("abort_entries", 64'(got.size()), 64'(7));
      run_dump(0, 0, 1'b0, 1'b0, 1'b1);

      // abort together with start in IDLE: no dump
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      check("abort_start_busy", 64'(busy), 64'(0));
      @(posedge clk); #1;
      check("abort_start_idle", 64'(busy | dump_if.out_valid), 64'(0));

      run_dump(0, 1, 1'b0, 1'b1, 1'b0);
      preload(1'b0);
      run_dump(0, 1, 1'b1, 1'b0, 1'b0);

      // Reset in the middle of a dump
      dump_until(12);
      d0 = done_cnt;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_idle_outputs("mid_reset");
      check("mid_reset_data", 64'(dump_if.out_data), 64'(0));
      check("mid_reset_index", 64'(dump_if.out_index), 64'(0));
      repeat (3) @(posedge clk);
      #1;
      check("mid_reset_no_done", 64'(done_cnt), 64'(d0));
      run_dump(0, 0, 1'b0, 1'b0, 1'b1);

      for (int t = 0; t < 6; t++) begin
         preload(1'b1);
         first = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(26, 31));
         rmode = int'($urandom_range(0, 1));
         run_dump(first, rmode, 1'b0, 1'b0, rmode == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
